sram_responder: RTL and testbench



---
 rtl/sram_resp_pkg.sv | 35 +++
 rtl/sram_byte_array.sv | 51 +++++
 rtl/sram_responder.sv | 124 ++++++++++++
 tb/tb_sram_responder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_resp_pkg.sv
// Shared constants and helpers for the SRAM responder.
// Holds the kseg fold mask, write-strobe constants and byte-merge helper.
package sram_resp_pkg;

    // Clearing the top three bits aliases kseg0/kseg1 onto physical space.
    localparam logic [31:0] KSEG_MASK = 32'h1FFF_FFFF;

    localparam logic [3:0] WE_NONE = 4'b0000;
    localparam logic [3:0] WE_WORD = 4'b1111;

    function automatic logic [31:0] fold_addr(
        input logic [31:0] addr
    );
        return addr & KSEG_MASK;
    endfunction

    // Lane i of the result comes from newWord when we[i] is set.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] oldWord,
        input logic [31:0] newWord,
        input logic [3:0]  we
    );
        logic [31:0] res;
        if (we == WE_WORD) begin
            res = newWord;
        end else begin
            for (int i = 0; i < 4; i++) begin
                res[8*i +: 8] = we[i] ? newWord[8*i +: 8]
                                      : oldWord[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_byte_array.sv
// Byte-lane word array: one write port, two synchronous read ports.
// Ports: clk; instRd/instIdx -> instWord; dataRd/dataWe/dataIdx/dataWdata
// -> dataWord. Read registers are not reset. The instruction port always
// sees the old word; with SRAM_RESP_WR_BYPASS_EN defined the data port
// sees the merged word on a write (write-first), else the old word.
module sram_byte_array
    import sram_resp_pkg::*;
#(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          instRd,
    input  logic [AW-1:0] instIdx,
    input  logic          dataRd,
    input  logic [3:0]    dataWe,
    input  logic [AW-1:0] dataIdx,
    input  logic [31:0]   dataWdata,
    output logic [31:0]   instWord,
    output logic [31:0]   dataWord
);

    localparam int DEPTH = 1 << AW;

    logic [31:0] mem [0:DEPTH-1];
    logic [31:0] dataOld;
    logic [31:0] dataNext;

    assign dataOld = mem[dataIdx];

`ifdef SRAM_RESP_WR_BYPASS_EN
    // Strobe of zero leaves the old word untouched, so reads pass through.
    assign dataNext = merge_bytes(dataOld, dataWdata, dataWe);
`else
    assign dataNext = dataOld;
`endif

    always_ff @(posedge clk) begin
        if (instRd) begin
            instWord <= mem[instIdx];
        end
        if (dataRd) begin
            dataWord <= dataNext;
        end
        for (int i = 0; i < 4; i++) begin
            if (dataWe[i]) begin
                mem[dataIdx][8*i +: 8] <= dataWdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/sram_responder.sv
// Memory-side responder for the core's SRAM-style fetch and data ports.
// Ports: clk, rst (sync, active-high); inst_en/inst_addr -> inst_rdata;
// data_en/data_we/data_addr/data_wdata -> data_rdata; err_flag, err_addr,
// err_cnt report out-of-range accesses. Optional macro:
// SRAM_RESP_WR_BYPASS_EN (write-first data read on a store).
module sram_responder
    import sram_resp_pkg::*;
#(
    parameter int WORD_AW = 14,
    parameter int ERR_CW  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_en,
    input  logic [31:0]       inst_addr,
    output logic [31:0]       inst_rdata,
    input  logic              data_en,
    input  logic [3:0]        data_we,
    input  logic [31:0]       data_addr,
    input  logic [31:0]       data_wdata,
    output logic [31:0]       data_rdata,
    output logic              err_flag,
    output logic [31:0]       err_addr,
    output logic [ERR_CW-1:0] err_cnt
);

    localparam logic [ERR_CW-1:0] ERR_MAX = '1;

    logic [31:0]        instPa;
    logic [31:0]        dataPa;
    logic               instOob;
    logic               dataOob;
    logic               instFault;
    logic               dataFault;
    logic               instRd;
    logic               dataRd;
    logic [3:0]         dataWeEff;
    logic [31:0]        instWord;
    logic [31:0]        dataWord;
    logic               instZeroQ;
    logic               dataZeroQ;
    logic               errFlagQ;
    logic [31:0]        errAddrQ;
    logic [ERR_CW-1:0]  errCntQ;
    logic [ERR_CW-1:0]  errCntNext;
    logic [ERR_CW:0]    errSum;
    logic [1:0]         faultCount;

    assign instPa  = fold_addr(inst_addr);
    assign dataPa  = fold_addr(data_addr);
    assign instOob = |instPa[31:WORD_AW+2];
    assign dataOob = |dataPa[31:WORD_AW+2];

    assign instFault = inst_en && instOob;
    assign dataFault = data_en && dataOob;

    // Array access only for in-range requests outside reset.
    assign instRd    = inst_en && !instOob && !rst;
    assign dataRd    = data_en && !dataOob && !rst;
    assign dataWeEff = dataRd ? data_we : WE_NONE;

    sram_byte_array #(
        .AW (WORD_AW)
    ) uArray (
        .clk       (clk),
        .instRd    (instRd),
        .instIdx   (instPa[WORD_AW+1:2]),
        .dataRd    (dataRd),
        .dataWe    (dataWeEff),
        .dataIdx   (dataPa[WORD_AW+1:2]),
        .dataWdata (data_wdata),
        .instWord  (instWord),
        .dataWord  (dataWord)
    );

    // The array read registers carry no reset, so a per-port flag forces
    // the visible word to zero after reset or an out-of-range request.
    // Idle cycles leave both flag and array register alone: output holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            instZeroQ <= 1'b1;
            dataZeroQ <= 1'b1;
        end else begin
            if (inst_en) begin
                instZeroQ <= instOob;
            end
            if (data_en) begin
                dataZeroQ <= dataOob;
            end
        end
    end

    assign inst_rdata = instZeroQ ? 32'h0 : instWord;
    assign data_rdata = dataZeroQ ? 32'h0 : dataWord;

    assign faultCount = {1'b0, instFault} + {1'b0, dataFault};
    assign errSum     = {1'b0, errCntQ} + (ERR_CW+1)'(faultCount);

    always_comb begin
        errCntNext = errSum[ERR_CW-1:0];
        if (errSum > {1'b0, ERR_MAX}) begin
            errCntNext = ERR_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            errFlagQ <= 1'b0;
            errAddrQ <= 32'h0;
            errCntQ  <= '0;
        end else begin
            if (!errFlagQ && (instFault || dataFault)) begin
                errFlagQ <= 1'b1;
                errAddrQ <= dataFault ? dataPa : instPa;
            end
            errCntQ <= errCntNext;
        end
    end

    assign err_flag = errFlagQ;
    assign err_addr = errAddrQ;
    assign err_cnt  = errCntQ;

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder (WORD_AW=14, ERR_CW=2).
// Expected outputs are queued at drive time and popped after the edge.
module tb_sram_responder;

    localparam int AW = 14;
    localparam int CW = 2;
    localparam int CNT_MAX = (1 << CW) - 1;
`ifdef SRAM_RESP_WR_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          instEn = 1'b0;
    logic [31:0]   instAddr = '0;
    logic [31:0]   instRdata;
    logic          dataEn = 1'b0;
    logic [3:0]    dataWe = '0;
    logic [31:0]   dataAddr = '0;
    logic [31:0]   dataWdata = '0;
    logic [31:0]   dataRdata;
    logic          errFlag;
    logic [31:0]   errAddr;
    logic [CW-1:0] errCnt;

    always #5 clk = ~clk;

    sram_responder #(
        .WORD_AW (AW),
        .ERR_CW  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_en    (instEn),
        .inst_addr  (instAddr),
        .inst_rdata (instRdata),
        .data_en    (dataEn),
        .data_we    (dataWe),
        .data_addr  (dataAddr),
        .data_wdata (dataWdata),
        .data_rdata (dataRdata),
        .err_flag   (errFlag),
        .err_addr   (errAddr),
        .err_cnt    (errCnt)
    );

    typedef struct {
        int          sel;
        logic [31:0] val;
    } expEntry_t;

    expEntry_t   expQ[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] memModel [int];
    logic [31:0] mInst = '0;
    logic [31:0] mData = '0;
    bit          mInstKnown = 1'b1;
    bit          mDataKnown = 1'b1;
    bit          mFlag = 1'b0;
    logic [31:0] mAddr = '0;
    int          mCnt = 0;

    task automatic checkVal(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void push(input int sel, input logic [31:0] val);
        expEntry_t e;
        e.sel = sel;
        e.val = val;
        expQ.push_back(e);
    endfunction

    task automatic step(input bit iEn, input logic [31:0] iAddr,
                        input bit dEn, input logic [3:0] dWe,
                        input logic [31:0] dAddr, input logic [31:0] dWd,
                        input bit isRst);
        logic [31:0] iPa, dPa, old, merged;
        bit          iOob, dOob, oldKnown, iF, dF;
        int          iIdx, dIdx;
        rst       = isRst;
        instEn    = iEn;
        instAddr  = iAddr;
        dataEn    = dEn;
        dataWe    = dWe;
        dataAddr  = dAddr;
        dataWdata = dWd;
        if (isRst) begin
            mInst = '0; mData = '0;
            mInstKnown = 1'b1; mDataKnown = 1'b1;
            mFlag = 1'b0; mAddr = '0; mCnt = 0;
        end else begin
            iPa  = {3'b000, iAddr[28:0]};
            dPa  = {3'b000, dAddr[28:0]};
            iOob = (iPa >> (AW + 2)) != 0;
            dOob = (dPa >> (AW + 2)) != 0;
            iIdx = int'(iPa[AW+1:2]);
            dIdx = int'(dPa[AW+1:2]);
            if (iEn) begin
                if (iOob) begin
                    mInst = '0; mInstKnown = 1'b1;
                end else begin
                    mInstKnown = memModel.exists(iIdx);
                    mInst = mInstKnown ? memModel[iIdx] : 'x;
                end
            end
            if (dEn) begin
                if (dOob) begin
                    mData = '0; mDataKnown = 1'b1;
                end else begin
                    oldKnown = memModel.exists(dIdx);
                    old = oldKnown ? memModel[dIdx] : 'x;
                    for (int i = 0; i < 4; i++) begin
                        merged[8*i +: 8] = dWe[i] ? dWd[8*i +: 8]
                                                  : old[8*i +: 8];
                    end
                    if (BYPASS && dWe != 4'b0) begin
                        mData = merged;
                        mDataKnown = oldKnown || dWe == 4'hF;
                    end else begin
                        mData = old;
                        mDataKnown = oldKnown;
                    end
                    if (dWe != 4'b0) memModel[dIdx] = merged;
                end
            end
            iF = iEn && iOob;
            dF = dEn && dOob;
            if (!mFlag && (iF || dF)) begin
                mFlag = 1'b1;
                mAddr = dF ? dPa : iPa;
            end
            mCnt = mCnt + int'(iF) + int'(dF);
            if (mCnt > CNT_MAX) mCnt = CNT_MAX;
        end
        if (mInstKnown) push(0, mInst);
        if (mDataKnown) push(1, mData);
        push(2, {31'b0, mFlag});
        push(3, mAddr);
        push(4, mCnt);
        @(posedge clk);
        #1;
        while (expQ.size() > 0) begin
            expEntry_t e;
            e = expQ.pop_front();
            case (e.sel)
                0: checkVal("inst_rdata", instRdata, e.val);
                1: checkVal("data_rdata", dataRdata, e.val);
                2: checkVal("err_flag", {31'b0, errFlag}, e.val);
                3: checkVal("err_addr", errAddr, e.val);
                default: checkVal("err_cnt", {30'b0, errCnt}, e.val);
            endcase
        end
    endtask

    task automatic idle(input logic [31:0] a);
        step(1'b0, a, 1'b0, 4'hF, a ^ 32'h0FF0_0000, a, 1'b0);
    endtask

    initial begin
        // Reset with random requests in flight.
        repeat (2) step(1'b1, $urandom, 1'b1, 4'($urandom), 32'h200,
                        $urandom, 1'b1);
        step(1'b0, 0, 1'b1, 4'hF, 32'h200, 32'h0BAD_F00D, 1'b0);
        repeat (2) step(1'b1, $urandom, 1'b1, 4'hF, 32'h200,
                        $urandom, 1'b1);
        step(1'b1, 32'h200, 1'b1, 4'h0, 32'h8000_0200, 0, 1'b0);

        // Folding and byte-lane merge.
        step(1'b0, 0, 1'b1, 4'hF, 32'hA000_0100, 32'h1122_3344, 1'b0);
        step(1'b0, 0, 1'b1, 4'b0010, 32'h8000_0100, 32'h0000_AA00, 1'b0);
        step(1'b1, 32'hE000_0100, 1'b1, 4'h0, 32'h0000_0100, 0, 1'b0);

        // Same-cycle read and write of one word.
        step(1'b0, 0, 1'b1, 4'hF, 32'h300, 32'h0, 1'b0);
        step(1'b1, 32'h300, 1'b1, 4'hF, 32'h300, 32'hDEAD_BEEF, 1'b0);
        step(1'b1, 32'h300, 1'b1, 4'h0, 32'h300, 0, 1'b0);

        // Hold while idle with addresses moving.
        step(1'b0, 0, 1'b1, 4'hF, 32'h100, 32'hCAFE_0001, 1'b0);
        step(1'b1, 32'h100, 1'b1, 4'h0, 32'h100, 0, 1'b0);
        for (int i = 0; i < 5; i++) idle(32'h0001_0000 + 32'(i) * 32'h44);

        // Out-of-range write dropped, then out-of-range fetch.
        step(1'b0, 0, 1'b1, 4'hF, 32'h0, 32'h1234_5678, 1'b0);
        step(1'b0, 0, 1'b1, 4'hF, 32'h0001_0000, 32'hFFFF_FFFF, 1'b0);
        step(1'b1, 32'h0002_0000, 1'b0, 4'h0, 0, 0, 1'b0);
        step(1'b1, 32'h0, 1'b1, 4'h0, 32'h0, 0, 1'b0);

        // Saturation: first-fault address must stay put.
        for (int i = 0; i < 8; i++) begin
            step(i[0], 32'h0008_0000 + 32'(i) * 4, 1'b1, 4'h0,
                 32'h0010_0000 + 32'(i) * 4, 0, 1'b0);
        end

        // Both ports fault together: data address wins.
        step(1'b0, 0, 1'b0, 4'h0, 0, 0, 1'b1);
        step(1'b1, 32'h0004_0000, 1'b1, 4'h0, 32'hBFC0_0100, 0, 1'b0);
        step(1'b1, 32'h100, 1'b1, 4'h0, 32'h0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
